// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: data-memory wait FSM with timeout,
// load-use and fetch-wait stalls, branch redirect flushes, and saturating stall/flush counters.
module pipeline_ctrl #(
   parameter int unsigned DM_TIMEOUT = 16,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rf_waddr,
   input  logic             ex_branch_taken,
   input  logic             mem_dm_req,
   input  logic             dm_ready,
   input  logic             im_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             dm_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic {RUN, DM_WAIT} state_t;

   localparam logic [7:0] TIMEOUT = 8'(DM_TIMEOUT);

   state_t     state;
   logic [7:0] wait_cnt;
   logic       load_use, timeout, freeze, branch_apply;

   // x0 is never a real destination, so it can never create a hazard
   assign load_use = ex_mem_read && (ex_rf_waddr != 5'd0) &&
                     ((id_rs1_used && (id_rs1 == ex_rf_waddr)) ||
                      (id_rs2_used && (id_rs2 == ex_rf_waddr)));

   assign timeout = (state == DM_WAIT) && !dm_ready && (wait_cnt == TIMEOUT);

   assign freeze = ((state == RUN) && mem_dm_req && !dm_ready) ||
                   ((state == DM_WAIT) && !dm_ready && !timeout);

   assign branch_apply = rstn && !freeze && ex_branch_taken;

   always_comb begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b0;
      id_ex_en    = 1'b0;
      id_ex_flush = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      dm_err      = rstn && timeout;
      if (rstn && !freeze) begin
         pc_en     = 1'b1;
         if_id_en  = 1'b1;
         id_ex_en  = 1'b1;
         ex_mem_en = 1'b1;
         mem_wb_en = 1'b1;
         // the ID instruction is wrong-path on a taken branch, so branch beats load-use
         if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
         end else if (!im_ready) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= RUN;
         wait_cnt <= 8'd0;
      end else begin
         case (state)
            RUN: begin
               if (mem_dm_req && !dm_ready) begin
                  state    <= DM_WAIT;
                  wait_cnt <= 8'd1;
               end
            end
            DM_WAIT: begin
               if (dm_ready || timeout) begin
                  state    <= RUN;
                  wait_cnt <= 8'd0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: begin
               state    <= RUN;
               wait_cnt <= 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_en && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (branch_apply && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed cycles push hand-computed outputs into a queue,
// a negedge monitor pops and compares enables/flushes/dm_err and both counters.
module tb_pipeline_ctrl;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rstn;
   logic [4:0]    id_rs1, id_rs2, ex_rf_waddr;
   logic          id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken;
   logic          mem_dm_req, dm_ready, im_ready;
   logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
   logic          ex_mem_en, mem_wb_en, dm_err;
   logic [CW-1:0] stall_cnt, flush_cnt;

   typedef struct {
      logic [7:0]    outs;
      logic [CW-1:0] stall;
      logic [CW-1:0] flush;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, dm_err}
   localparam logic [7:0] RST = 8'b00000000;
   localparam logic [7:0] FRZ = 8'b00000000;
   localparam logic [7:0] DEF = 8'b11010110;
   localparam logic [7:0] LU  = 8'b00011110;
   localparam logic [7:0] FW  = 8'b01110110;
   localparam logic [7:0] BR  = 8'b11111110;
   localparam logic [7:0] ERR = 8'b11010111;

   pipeline_ctrl #(.DM_TIMEOUT(4), .CNT_W(CW)) dut (
      .clk(clk), .rstn(rstn),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_mem_read(ex_mem_read), .ex_rf_waddr(ex_rf_waddr),
      .ex_branch_taken(ex_branch_taken),
      .mem_dm_req(mem_dm_req), .dm_ready(dm_ready), .im_ready(im_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
      .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
      .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
      .dm_err(dm_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t       e;
         logic [7:0] act;
         e   = q.pop_front();
         act = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, dm_err};
         n_chk++;
         if (act !== e.outs) begin
            n_fail++;
            $display("FAIL outs @%0t: got %b want %b", $time, act, e.outs);
         end
         n_chk++;
         if (stall_cnt !== e.stall) begin
            n_fail++;
            $display("FAIL stall_cnt @%0t: got %0d want %0d", $time, stall_cnt, e.stall);
         end
         n_chk++;
         if (flush_cnt !== e.flush) begin
            n_fail++;
            $display("FAIL flush_cnt @%0t: got %0d want %0d", $time, flush_cnt, e.flush);
         end
      end
   end

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
      ex_mem_read = 1'b0; ex_rf_waddr = 5'd0; ex_branch_taken = 1'b0;
      mem_dm_req = 1'b0; dm_ready = 1'b0; im_ready = 1'b1;
   endtask

   // inputs are already set; record what this cycle must show, then advance one clock
   task automatic cyc(input logic [7:0] o, input int st, input int fl);
      exp_t e;
      e.outs  = o;
      e.stall = CW'(st);
      e.flush = CW'(fl);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic load_use_rs1();
      ex_mem_read = 1'b1; ex_rf_waddr = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
   endtask

   initial begin
      idle();
      rstn = 1'b0;
      @(posedge clk); #1;
      cyc(RST, 0, 0);
      rstn = 1'b1;

      load_use_rs1();               cyc(LU, 0, 0);
      idle();                       cyc(DEF, 1, 0);
      ex_mem_read = 1'b1; ex_rf_waddr = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
                                    cyc(LU, 1, 0);
      id_rs2_used = 1'b0;           cyc(DEF, 2, 0);
      idle();
      ex_mem_read = 1'b1; ex_rf_waddr = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
                                    cyc(DEF, 2, 0);

      idle(); im_ready = 1'b0;      cyc(FW, 2, 0);
      idle();                       cyc(DEF, 3, 0);
      load_use_rs1(); im_ready = 1'b0;
                                    cyc(LU, 3, 0);
      idle();                       cyc(DEF, 4, 0);

      mem_dm_req = 1'b1;            cyc(FRZ, 4, 0);
                                    cyc(FRZ, 5, 0);
                                    cyc(FRZ, 6, 0);
      dm_ready = 1'b1;              cyc(DEF, 7, 0);
                                    cyc(DEF, 7, 0);
      idle();                       cyc(DEF, 7, 0);

      load_use_rs1(); im_ready = 1'b0; ex_branch_taken = 1'b1;
                                    cyc(BR, 7, 0);
      idle();                       cyc(DEF, 7, 1);

      mem_dm_req = 1'b1; ex_branch_taken = 1'b1;
                                    cyc(FRZ, 7, 1);
                                    cyc(FRZ, 8, 1);
      dm_ready = 1'b1;              cyc(BR, 9, 1);
      idle();                       cyc(DEF, 9, 2);

      mem_dm_req = 1'b1;            cyc(FRZ, 9, 2);
                                    cyc(FRZ, 10, 2);
                                    cyc(FRZ, 11, 2);
                                    cyc(FRZ, 12, 2);
                                    cyc(ERR, 13, 2);
      idle();                       cyc(DEF, 13, 2);

      im_ready = 1'b0;              cyc(FW, 13, 2);
                                    cyc(FW, 14, 2);
                                    cyc(FW, 15, 2);
                                    cyc(FW, 15, 2);
      idle();                       cyc(DEF, 15, 2);

      mem_dm_req = 1'b1;            cyc(FRZ, 15, 2);
                                    cyc(FRZ, 15, 2);
      rstn = 1'b0;                  cyc(RST, 15, 2);
                                    cyc(RST, 0, 0);
      rstn = 1'b1; idle();          cyc(DEF, 0, 0);
      mem_dm_req = 1'b1;            cyc(FRZ, 0, 0);
                                    cyc(FRZ, 1, 0);
                                    cyc(FRZ, 2, 0);
                                    cyc(FRZ, 3, 0);
      dm_ready = 1'b1;              cyc(DEF, 4, 0);
      idle();                       cyc(DEF, 4, 0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d entries left want 0", q.size());
      end
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
